frac_lut4_cfg_loader: RTL and testbench



---
 rtl/frac_lut4_cfg_pkg.sv | 27 ++
 rtl/frac_lut4_cfg_loader_piso.sv | 37 +++
 rtl/frac_lut4_cfg_loader.sv | 157 +++++++++++++++
 tb/tb_frac_lut4_cfg_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_lut4_cfg_pkg.sv
// ---------------------------------------------------------------------------
// frac_lut4_cfg_pkg
// Shared definitions for the frac_lut4 configuration loader.
//   WORD_W   : bits per tile configuration word (16 sram + 1 mode)
//   SRAM_W   : truth-table bits per tile
//   MODE_BIT : index of the mode bit within a word (shifted out first)
//   cfg_state_e : loader FSM states
// ---------------------------------------------------------------------------
package frac_lut4_cfg_pkg;

    localparam int WORD_W   = 17;
    localparam int SRAM_W   = 16;
    localparam int MODE_BIT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } cfg_state_e;

    // A load is in progress while waiting for or shifting a word.
    function automatic logic state_is_busy(input cfg_state_e s);
        return (s == LOAD) || (s == SHIFT);
    endfunction

endpackage

// File: rtl/frac_lut4_cfg_loader_piso.sv
// ---------------------------------------------------------------------------
// cfg_piso_shreg
// 17-bit parallel-load, MSB-first serial-out shift register.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_load  : capture i_data (has priority over i_shift)
//   i_shift : shift one position towards the MSB, zero fill
//   i_data  : parallel word, bit MODE_BIT is the first bit out
//   o_msb   : current serial output bit
// ---------------------------------------------------------------------------
module cfg_piso_shreg
    import frac_lut4_cfg_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_msb
);

    logic [WORD_W-1:0] r_shreg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[SRAM_W-1:0], 1'b0};
        end
    end

    assign o_msb = r_shreg[MODE_BIT];

endmodule

// File: rtl/frac_lut4_cfg_loader.sv
// ---------------------------------------------------------------------------
// frac_lut4_cfg_loader
// Loads NUM_LUTS 17-bit configuration words from a valid/ready stream onto
// the serial configuration flip-flop chain of the frac_lut4 tiles.
// Each word is sent mode bit first, then sram[15] down to sram[0], so the
// first word accepted ends up in the tile farthest from the chain head.
// Ports:
//   prog_clk, prog_reset_n : clock / asynchronous active-low reset
//   start, abort           : begin a full-chain load / terminate it
//   cfg_valid, cfg_ready   : word stream handshake
//   cfg_data[0:16]         : [0:15] = sram[0:15], [16] = mode
//   ccff_head              : serial bit into the chain
//   ccff_shift_en          : chain shifts on this edge
//   busy, done, aborted    : status; done/aborted are one-cycle pulses
//   words_loaded           : words fully shifted in the current/last load
// ---------------------------------------------------------------------------
module frac_lut4_cfg_loader
    import frac_lut4_cfg_pkg::*;
#(
    parameter  int NUM_LUTS = 4,
    localparam int CNT_W    = $clog2(NUM_LUTS + 1)
) (
    input  logic             prog_clk,
    input  logic             prog_reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [0:16]      cfg_data,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [4:0]     LP_BIT_LAST  = 5'(WORD_W - 1);
    localparam logic [CNT_W:0] LP_LAST_WORD = (CNT_W + 1)'(NUM_LUTS);

    cfg_state_e        r_state;
    cfg_state_e        w_state_next;
    logic [4:0]        r_bit_cnt;
    logic [CNT_W-1:0]  r_words_loaded;
    logic              r_aborted;
    logic              w_abort_take;
    logic              w_handshake;
    logic              w_bit_last;
    logic              w_word_done;
    logic [CNT_W:0]    w_wl_inc;
    logic [WORD_W-1:0] w_word;
    logic              w_msb;

    // The port is declared ascending; keep index i of the port at index i
    // of the internal word so that sram[0] is always bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_word_map
            assign w_word[gi] = cfg_data[gi];
        end
    endgenerate

    assign w_handshake = (r_state == LOAD) && cfg_valid && !abort;
    assign w_bit_last  = (r_bit_cnt == LP_BIT_LAST);
    // abort wins over completion of the 17th shift
    assign w_word_done = (r_state == SHIFT) && w_bit_last && !abort;
    // one bit wider so NUM_LUTS itself is representable at any CNT_W
    assign w_wl_inc    = {1'b0, r_words_loaded} + (CNT_W + 1)'(1);

    // State register
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_abort_take = 1'b0;
        case (r_state)
            IDLE: begin
                // abort is ignored here, so start+abort simply starts
                if (start) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    w_state_next = IDLE;
                    w_abort_take = 1'b1;
                end else if (cfg_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_state_next = IDLE;
                    w_abort_take = 1'b1;
                end else if (w_bit_last) begin
                    w_state_next = (w_wl_inc == LP_LAST_WORD) ? DONE : LOAD;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Counters and the abort pulse
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_bit_cnt      <= '0;
            r_words_loaded <= '0;
            r_aborted      <= 1'b0;
        end else begin
            r_aborted <= w_abort_take;

            if ((r_state == IDLE) && start) begin
                r_words_loaded <= '0;
            end else if (w_word_done) begin
                r_words_loaded <= w_wl_inc[CNT_W-1:0];
            end

            if (w_handshake) begin
                r_bit_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    cfg_piso_shreg u_piso (
        .i_clk   (prog_clk),
        .i_rst_n (prog_reset_n),
        .i_load  (w_handshake),
        .i_shift (r_state == SHIFT),
        .i_data  (w_word),
        .o_msb   (w_msb)
    );

    // All outputs decode flops only; no input reaches an output
    // combinationally.
    assign cfg_ready     = (r_state == LOAD);
    assign ccff_shift_en = (r_state == SHIFT);
    assign ccff_head     = w_msb && (r_state == SHIFT);
    assign busy          = state_is_busy(r_state);
    assign done          = (r_state == DONE);
    assign aborted       = r_aborted;
    assign words_loaded  = r_words_loaded;

endmodule

// File: tb/tb_frac_lut4_cfg_loader.sv
module tb_frac_lut4_cfg_loader;

    logic        prog_clk;
    logic        prog_reset_n;

    // NUM_LUTS = 4 instance
    logic        start4, abort4, valid4;
    logic [0:16] data4;
    logic        ready4, head4, sen4, busy4, done4, aborted4;
    logic [2:0]  wl4;

    // NUM_LUTS = 1 instance
    logic        start1, abort1, valid1;
    logic [0:16] data1;
    logic        ready1, head1, sen1, busy1, done1, aborted1;
    logic [0:0]  wl1;

    int checks = 0;
    int errors = 0;

    frac_lut4_cfg_loader #(.NUM_LUTS(4)) u_dut4 (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start4),
        .abort         (abort4),
        .cfg_valid     (valid4),
        .cfg_ready     (ready4),
        .cfg_data      (data4),
        .ccff_head     (head4),
        .ccff_shift_en (sen4),
        .busy          (busy4),
        .done          (done4),
        .aborted       (aborted4),
        .words_loaded  (wl4)
    );

    frac_lut4_cfg_loader #(.NUM_LUTS(1)) u_dut1 (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start1),
        .abort         (abort1),
        .cfg_valid     (valid1),
        .cfg_ready     (ready1),
        .cfg_data      (data1),
        .ccff_head     (head1),
        .ccff_shift_en (sen1),
        .busy          (busy1),
        .done          (done1),
        .aborted       (aborted1),
        .words_loaded  (wl1)
    );

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    typedef struct {
        logic [3:0][16:0] w;        // w[0] is the first word sent
        int gap_idx;                // word index preceded by a valid gap (-1 none)
        int gap_len;                // ready-high cycles with valid low
        int abort_word;             // word index to abort in (-1 none)
        int abort_shift;            // abort during this shift cycle (1..17)
        int start_busy_cyc;         // extra start pulse while busy (-1 none)
        bit start_with_abort;       // abort raised together with start
        int exp_done_cyc;           // cycle of done after the start cycle (-1 none)
        int exp_shifts;
        int exp_wl;
        int exp_aborted;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [0:16] to_port(input logic [16:0] w);
        logic [0:16] p;
        for (int i = 0; i < 17; i++) p[i] = w[i];
        return p;
    endfunction

    function automatic vec_t mk(input logic [16:0] w0, input logic [16:0] w1,
                                input logic [16:0] w2, input logic [16:0] w3,
                                input int gi, input int gl, input int aw, input int as,
                                input int sb, input bit swa,
                                input int edc, input int esh, input int ewl, input int eab);
        vec_t v;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.gap_idx = gi; v.gap_len = gl; v.abort_word = aw; v.abort_shift = as;
        v.start_busy_cyc = sb; v.start_with_abort = swa;
        v.exp_done_cyc = edc; v.exp_shifts = esh; v.exp_wl = ewl; v.exp_aborted = eab;
        return v;
    endfunction

    // Drives one full-chain load on the 4-tile instance and checks it against
    // the expectations in v. Entered and left at a falling edge with the DUT idle.
    task automatic run_load(input vec_t v, input string tag);
        logic chain[$];
        int   idx, gap_left, shifts, cur_shifts, done_cyc, n_done, n_aborted;
        int   inv_bad, stop_at;
        bit   hs_pending, gap_prev, abort_sent, abort_resp;
        logic [16:0] tile;

        chain.delete();
        idx = 0; gap_left = v.gap_len; shifts = 0; cur_shifts = 0;
        done_cyc = -1; n_done = 0; n_aborted = 0; inv_bad = 0; stop_at = 400;
        gap_prev = 0; abort_sent = 0; abort_resp = 0;

        // cycle 0: start request
        start4 = 1'b1;
        abort4 = v.start_with_abort;
        valid4 = 1'b0;
        hs_pending = 1'b0;

        for (int cyc = 1; cyc <= stop_at; cyc++) begin
            @(negedge prog_clk);
            start4 = 1'b0;
            abort4 = 1'b0;

            if (cyc == 1 && wl4 !== 3'd0) inv_bad++;
            if (hs_pending) begin
                // cfg_ready drops right after the handshake, shifting begins
                if (ready4 !== 1'b0 || sen4 !== 1'b1) inv_bad++;
                idx++;
                cur_shifts = 0;
            end
            if (gap_prev && (ready4 !== 1'b1 || sen4 !== 1'b0)) inv_bad++;
            if (abort_resp) begin
                check({tag, "_abort_pulse"}, {29'd0, aborted4, sen4, busy4}, 32'b100);
                abort_resp = 0;
            end

            if (sen4 === 1'b1) begin
                shifts++;
                cur_shifts++;
                chain.push_front(head4);
            end else if (head4 !== 1'b0) begin
                inv_bad++;
            end
            if (done4 === 1'b1) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                if (busy4 !== 1'b0 || sen4 !== 1'b0) inv_bad++;
                if (stop_at == 400) stop_at = cyc + 3;
            end
            if (aborted4 === 1'b1) begin
                n_aborted++;
                if (stop_at == 400) stop_at = cyc + 3;
            end

            // next-cycle stimulus
            if (cyc == v.start_busy_cyc) start4 = 1'b1;
            if (v.abort_word >= 0 && !abort_sent && sen4 === 1'b1 &&
                idx == v.abort_word + 1 && cur_shifts == v.abort_shift) begin
                abort4 = 1'b1;
                abort_sent = 1;
                abort_resp = 1;
            end
            gap_prev = 0;
            if (idx < 4) begin
                if (ready4 === 1'b1 && idx == v.gap_idx && gap_left > 0) begin
                    valid4 = 1'b0;
                    gap_left--;
                    gap_prev = 1;
                end else begin
                    valid4 = 1'b1;
                    data4 = to_port(v.w[idx]);
                end
            end else begin
                valid4 = 1'b0;
            end
            hs_pending = valid4 && (ready4 === 1'b1) && !abort4;
        end
        valid4 = 1'b0;

        check({tag, "_finished"}, (stop_at != 400), 1);
        check({tag, "_done_cycle"}, done_cyc, v.exp_done_cyc);
        check({tag, "_shift_count"}, shifts, v.exp_shifts);
        check({tag, "_done_pulses"}, n_done, (v.exp_done_cyc > 0) ? 1 : 0);
        check({tag, "_aborted_pulses"}, n_aborted, v.exp_aborted);
        check({tag, "_words_loaded"}, wl4, v.exp_wl);
        check({tag, "_cycle_rules"}, inv_bad, 0);
        if (v.exp_done_cyc > 0) begin
            // position 0 is next to the head; tile k spans positions 17k..17k+16
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 17; j++)
                    tile[j] = (17 * k + j < chain.size()) ? chain[17 * k + j] : 1'bx;
                check($sformatf("%s_tile%0d", tag, k), tile, v.w[3 - k]);
            end
        end
        $display("load %s: done_cyc=%0d shifts=%0d words_loaded=%0d aborted=%0d",
                 tag, done_cyc, shifts, wl4, n_aborted);
    endtask

    // Single-word load on the 1-tile instance; the head bits, packed in
    // arrival order, must reproduce the word.
    task automatic run_single(input logic [16:0] w, input string tag);
        logic [16:0] seq;
        int n_sh, done_cyc;
        seq = '0; n_sh = 0; done_cyc = -1;
        start1 = 1'b1;
        valid1 = 1'b1;
        data1  = to_port(w);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge prog_clk);
            start1 = 1'b0;
            if (sen1 === 1'b1) begin
                seq = {seq[15:0], head1};
                n_sh++;
            end
            if (done1 === 1'b1 && done_cyc < 0) done_cyc = cyc;
        end
        valid1 = 1'b0;
        check({tag, "_head_seq"}, seq, w);
        check({tag, "_shifts"}, n_sh, 17);
        check({tag, "_done_cycle"}, done_cyc, 19);
        check({tag, "_words_loaded"}, wl1, 1);
        $display("single %s: seq=%05h shifts=%0d done_cyc=%0d", tag, seq, n_sh, done_cyc);
    endtask

    vec_t vecs[5];

    initial begin
        vec_t rv;
        bit   seen;

        start4 = 0; abort4 = 0; valid4 = 0; data4 = '0;
        start1 = 0; abort1 = 0; valid1 = 0; data1 = '0;
        prog_reset_n = 1'b0;

        vecs[0] = mk(17'h1A5A5, 17'h00001, 17'h10000, 17'h0FFFF, -1, 0, -1, 0, -1, 0, 73, 68, 4, 0);
        vecs[1] = mk(17'h1A5A5, 17'h00001, 17'h10000, 17'h0FFFF,  1, 10, -1, 0, -1, 0, 83, 68, 4, 0);
        vecs[2] = mk(17'h1A5A5, 17'h00001, 17'h10000, 17'h0FFFF, -1, 0, 1, 5, -1, 0, -1, 22, 1, 1);
        vecs[3] = mk(17'h1A5A5, 17'h00001, 17'h10000, 17'h0FFFF, -1, 0, -1, 0, -1, 0, 73, 68, 4, 0);
        vecs[4] = mk(17'h0C3C3, 17'h13579, 17'h00000, 17'h1FFFF, -1, 0, -1, 0, 30, 1, 73, 68, 4, 0);

        repeat (2) @(negedge prog_clk);
        check("reset_ready",   ready4, 0);
        check("reset_head",    head4, 0);
        check("reset_shift",   sen4, 0);
        check("reset_busy",    busy4, 0);
        check("reset_done",    done4, 0);
        check("reset_aborted", aborted4, 0);
        check("reset_wl",      wl4, 0);
        check("reset_dut1", {ready1, head1, sen1, busy1, done1, aborted1, wl1}, 0);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);

        for (int i = 0; i < 5; i++) run_load(vecs[i], $sformatf("vec%0d", i));

        run_single(17'h10001, "one_10001");
        run_single(17'($urandom), "one_rand");

        // randomized loads: expectations follow from the word list, the gap
        // length and the abort point alone
        for (int r = 0; r < 6; r++) begin
            rv = mk(17'($urandom), 17'($urandom), 17'($urandom), 17'($urandom),
                    $urandom_range(1, 3), $urandom_range(0, 12), -1, 0, -1, 0, 0, 68, 4, 0);
            if ($urandom_range(0, 2) == 0) begin
                rv.abort_word   = $urandom_range(0, 3);
                rv.abort_shift  = $urandom_range(1, 17);
                rv.exp_done_cyc = -1;
                rv.exp_shifts   = 17 * rv.abort_word + rv.abort_shift;
                rv.exp_wl       = rv.abort_word;
                rv.exp_aborted  = 1;
            end else begin
                rv.exp_done_cyc = 18 * 4 + rv.gap_len + 1;
            end
            run_load(rv, $sformatf("rand%0d", r));
        end

        // asynchronous reset in the middle of shifting
        start4 = 1'b1;
        valid4 = 1'b1;
        data4  = to_port(17'h15555);
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge prog_clk);
            start4 = 1'b0;
            if (sen4 === 1'b1) seen = 1;
        end
        check("rst_reached_shift", seen, 1);
        repeat (3) @(posedge prog_clk);
        #2 prog_reset_n = 1'b0;
        #1;
        check("rst_async_outputs", {ready4, head4, sen4, busy4, done4, aborted4, wl4}, 0);
        valid4 = 1'b0;
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        $display("async reset mid-shift applied");
        @(negedge prog_clk);
        run_load(vecs[0], "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
